// File: rtl/control_fsm.sv
// Multi-cycle instruction controller: sequences fetch/decode/execute/memory/write-back
// and holds the decoded datapath controls stable for the whole instruction.
module control_fsm #(
    parameter int OP_W          = 4,
    parameter int FN_W          = 4,
    parameter int MULDIV_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] opcode,
    input  logic [FN_W-1:0] func,
    input  logic            mem_ack,
    input  logic            br_taken,
    output logic            mem_req,
    output logic            ir_we,
    output logic            pc_we,
    output logic            reg_we,
    output logic            OFFset,
    output logic            Imm,
    output logic            Down,
    output logic            Mbyte,
    output logic            MV1src,
    output logic            Halt,
    output logic [1:0]      Bra,
    output logic [1:0]      Wdst,
    output logic [1:0]      MemW,
    output logic            retire,
    output logic [2:0]      state
);

    localparam int CNT_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_ALU    = 3'd0,
        C_MULDIV = 3'd1,
        C_BRANCH = 3'd2,
        C_LOAD   = 3'd3,
        C_STORE  = 3'd4,
        C_HALT   = 3'd5
    } cls_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cls_t             cls_q;
    logic             off_q, imm_q, down_q, mbyte_q, mv1_q, halt_q;
    logic [1:0]       bra_q, wdst_q, memw_q;

    cls_t       dec_cls;
    logic       dec_off, dec_imm, dec_down, dec_mbyte, dec_mv1, dec_halt;
    logic [1:0] dec_bra, dec_wdst, dec_memw;
    logic       op_hi_ok;
    logic [3:0] opc4, fn4;

    assign opc4     = opcode[3:0];
    assign fn4      = func[3:0];
    assign op_hi_ok = ((opcode >> 4) == '0);

    // Opcodes with nonzero upper bits fall through to the NOP defaults.
    always_comb begin
        dec_cls   = C_ALU;
        dec_off   = 1'b0;
        dec_imm   = 1'b0;
        dec_down  = 1'b0;
        dec_mbyte = 1'b0;
        dec_mv1   = 1'b1;
        dec_halt  = 1'b0;
        dec_bra   = 2'b11;
        dec_wdst  = 2'b00;
        dec_memw  = 2'b00;
        if (op_hi_ok) begin
            case (opc4)
                4'b0000: begin
                    dec_halt = 1'b1;
                    dec_cls  = C_HALT;
                end
                4'b0100: begin dec_bra = 2'b10; dec_cls = C_BRANCH; end
                4'b0101: begin dec_bra = 2'b01; dec_cls = C_BRANCH; end
                4'b0110: begin dec_bra = 2'b00; dec_cls = C_BRANCH; end
                4'b1000, 4'b1001: dec_imm = 1'b1;
                4'b1010: begin
                    dec_off   = 1'b1;
                    dec_mbyte = 1'b1;
                    dec_down  = 1'b1;
                    dec_cls   = C_LOAD;
                end
                4'b1011: begin dec_off = 1'b1; dec_memw = 2'b01; dec_cls = C_STORE; end
                4'b1100: begin dec_off = 1'b1; dec_down = 1'b1;  dec_cls = C_LOAD;  end
                4'b1101: begin dec_off = 1'b1; dec_memw = 2'b10; dec_cls = C_STORE; end
                4'b1111: begin
                    case (fn4)
                        4'b0100, 4'b0101: begin dec_wdst = 2'b10; dec_cls = C_MULDIV; end
                        4'b0111: dec_mv1 = 1'b0;
                        4'b1000: begin dec_mv1 = 1'b0; dec_wdst = 2'b01; end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_req = 1'b0;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        reg_we  = 1'b0;
        retire  = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_cls == C_HALT) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                    cnt_d   = (dec_cls == C_MULDIV) ? CNT_LOAD : '0;
                end
            end
            S_EXEC: begin
                if (cls_q == C_MULDIV && cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    case (cls_q)
                        C_BRANCH: begin
                            pc_we   = br_taken;
                            retire  = 1'b1;
                            state_d = S_FETCH;
                        end
                        C_LOAD, C_STORE: state_d = S_MEM;
                        default:         state_d = S_WB;
                    endcase
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    if (cls_q == C_STORE) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
        // Reset silences every strobe in its own cycle, abandoning any request.
        if (rst) begin
            mem_req = 1'b0;
            ir_we   = 1'b0;
            pc_we   = 1'b0;
            reg_we  = 1'b0;
            retire  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            cls_q   <= C_ALU;
            off_q   <= 1'b0;
            imm_q   <= 1'b0;
            down_q  <= 1'b0;
            mbyte_q <= 1'b0;
            mv1_q   <= 1'b1;
            halt_q  <= 1'b0;
            bra_q   <= 2'b11;
            wdst_q  <= 2'b00;
            memw_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_DECODE) begin
                cls_q   <= dec_cls;
                off_q   <= dec_off;
                imm_q   <= dec_imm;
                down_q  <= dec_down;
                mbyte_q <= dec_mbyte;
                mv1_q   <= dec_mv1;
                halt_q  <= dec_halt;
                bra_q   <= dec_bra;
                wdst_q  <= dec_wdst;
                memw_q  <= dec_memw;
            end
        end
    end

    assign OFFset = off_q;
    assign Imm    = imm_q;
    assign Down   = down_q;
    assign Mbyte  = mbyte_q;
    assign MV1src = mv1_q;
    assign Halt   = halt_q;
    assign Bra    = bra_q;
    assign Wdst   = wdst_q;
    assign MemW   = memw_q;
    assign state  = state_q;

endmodule
